// File: rtl/i2c_paged_reg_slave.sv
// Write-only paged I2C register slave; write strobe 1 clk after the detected SCL rise of bit 8.
// No backpressure: every addressed byte is ACKed, and a mismatched address is ignored until START/STOP.
module i2c_paged_reg_slave #(
  parameter logic [6:0] SADR     = 7'b0010000,
  parameter logic [7:0] PAGE_CMD = 8'h01,
  parameter int         SYNC_STG = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        wr_valid,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [7:0]  page,
  output logic        busy,
  output logic        xfer_done
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, BYTE, BYTE_ACK, IGNORE} state_t;

  state_t state, state_nx;

  logic [SYNC_STG-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start, stop;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic [7:0] byte_in;
  logic [1:0] byte_idx;
  logic       pmode;
  logic [7:0] reg_ptr;
  logic       ack_drive;
  logic       shifting, in_ack, byte_done;

  // Synchronizers reset to the idle-bus level so release from reset never looks like an edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STG-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STG-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STG-1];
  assign sda_s     = sda_sync[SYNC_STG-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start     = scl_s & scl_d & sda_d & ~sda_s;
  assign stop      = scl_s & scl_d & ~sda_d & sda_s;
  assign byte_in   = {shreg, sda_s};
  assign shifting  = (state == ADDR) || (state == BYTE);
  assign in_ack    = (state == ADDR_ACK) || (state == BYTE_ACK);
  assign byte_done = shifting && scl_rise && (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = ADDR;
    end else if (stop) begin
      state_nx = IDLE;
    end else begin
      case (state)
        ADDR:     if (byte_done) state_nx = (byte_in == {SADR, 1'b0}) ? ADDR_ACK : IGNORE;
        ADDR_ACK: if (scl_fall && ack_drive) state_nx = BYTE;
        BYTE:     if (byte_done) state_nx = BYTE_ACK;
        BYTE_ACK: if (scl_fall && ack_drive) state_nx = BYTE;
        default:  state_nx = state;
      endcase
    end
  end

  // ACK is dropped combinationally on a bus condition so the line is free in the same clk
  always_comb begin
    sda_oe = ack_drive & ~start & ~stop;
    busy   = (state == ADDR_ACK) || (state == BYTE) || (state == BYTE_ACK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= 3'd0;
      shreg     <= 7'd0;
      byte_idx  <= 2'd0;
      pmode     <= 1'b0;
      reg_ptr   <= 8'h00;
      page      <= 8'h00;
      ack_drive <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= 16'h0000;
      wr_data   <= 8'h00;
      xfer_done <= 1'b0;
    end else begin
      wr_valid  <= 1'b0;
      xfer_done <= 1'b0;
      if (start || stop) begin
        bit_cnt   <= 3'd0;
        byte_idx  <= 2'd0;
        pmode     <= 1'b0;
        ack_drive <= 1'b0;
        xfer_done <= stop & busy;
      end else begin
        if (shifting && scl_rise) begin
          shreg   <= byte_in[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (byte_done && state == BYTE) begin
          if (byte_idx == 2'd0) begin
            if (byte_in == PAGE_CMD) begin
              pmode <= 1'b1;
            end else begin
              reg_ptr <= byte_in;
              pmode   <= 1'b0;
            end
          end else if (pmode) begin
            if (byte_idx == 2'd1) page <= byte_in;
          end else begin
            wr_valid <= 1'b1;
            wr_addr  <= {page, reg_ptr};
            wr_data  <= byte_in;
            reg_ptr  <= reg_ptr + 8'd1;
          end
          if (byte_idx != 2'd2) byte_idx <= byte_idx + 2'd1;
        end
        // First SCL fall in an ACK state starts driving, the second ends the ACK bit
        if (in_ack) begin
          if (scl_fall) ack_drive <= ~ack_drive;
        end else begin
          ack_drive <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_paged_reg_slave.sv
// Bench for i2c_paged_reg_slave: table of I2C write transactions plus hand-written
// repeated-START, partial-byte and reset-during-ACK sequences.
module tb_i2c_paged_reg_slave;

  localparam int Q = 5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        scl, sda_m;
  logic        sda_line;
  logic        sda_oe, wr_valid, busy, xfer_done;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data, page;

  int applied = 0;
  int miscompares = 0;

  logic [15:0] wa [64];
  logic [7:0]  wd [64];
  int wcnt = 0, xd_cnt = 0, busy_cyc = 0, oe_cyc = 0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_paged_reg_slave dut (
    .clk(clk), .reset_n(reset_n), .scl_i(scl), .sda_i(sda_line),
    .sda_oe(sda_oe), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .page(page), .busy(busy), .xfer_done(xfer_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_valid && wcnt < 64) begin
      wa[wcnt] = wr_addr;
      wd[wcnt] = wr_data;
      wcnt++;
    end
    if (xfer_done) xd_cnt++;
    if (busy) busy_cyc++;
    if (sda_oe) oe_cyc++;
  end

  typedef struct {
    logic [31:0] b;
    int          nb;
    logic [3:0]  ack_exp;
    int          nw;
    logic [15:0] a0;
    logic [7:0]  d0;
    logic [15:0] a1;
    logic [7:0]  d1;
    logic [7:0]  page_exp;
    int          xd_exp;
    logic        busy_exp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic wq;
    repeat (Q) @(posedge clk);
    #2;
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; scl = 1'b1; wq;
    sda_m = 1'b0; wq;
    scl = 1'b0; wq;
  endtask

  task automatic i2c_rep_start;
    sda_m = 1'b1; wq;
    scl = 1'b1; wq;
    sda_m = 1'b0; wq;
    scl = 1'b0; wq;
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; wq;
    scl = 1'b1; wq;
    sda_m = 1'b1; wq; wq;
  endtask

  task automatic i2c_bit(input logic b);
    sda_m = b; wq;
    scl = 1'b1; wq; wq;
    scl = 1'b0; wq;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
    sda_m = 1'b1; wq;
    scl = 1'b1; wq;
    ack = ~sda_line;
    wq;
    scl = 1'b0; wq;
  endtask

  initial begin
    int wb, xb, bb, ob;
    logic ack;
    logic [3:0] acks;
    logic [7:0] bv;

    tbl[0] = '{32'h20010500, 3, 4'b0111, 0, 16'h0,    8'h0,  16'h0,    8'h0,  8'h05, 1, 1'b1};
    tbl[1] = '{32'h2034AB00, 3, 4'b0111, 1, 16'h0534, 8'hAB, 16'h0,    8'h0,  8'h05, 1, 1'b1};
    tbl[2] = '{32'h20FF1122, 4, 4'b1111, 2, 16'h05FF, 8'h11, 16'h0500, 8'h22, 8'h05, 1, 1'b1};
    tbl[3] = '{32'h22340000, 2, 4'b0000, 0, 16'h0,    8'h0,  16'h0,    8'h0,  8'h05, 0, 1'b0};
    tbl[4] = '{32'h21340000, 2, 4'b0000, 0, 16'h0,    8'h0,  16'h0,    8'h0,  8'h05, 0, 1'b0};
    tbl[5] = '{32'h20010999, 4, 4'b1111, 0, 16'h0,    8'h0,  16'h0,    8'h0,  8'h09, 1, 1'b1};
    tbl[6] = '{32'h2010AABB, 4, 4'b1111, 2, 16'h0910, 8'hAA, 16'h0911, 8'hBB, 8'h09, 1, 1'b1};
    tbl[7] = '{32'h20010500, 3, 4'b0111, 0, 16'h0,    8'h0,  16'h0,    8'h0,  8'h05, 1, 1'b1};

    reset_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_page", page, 0);
    chk("rst_busy", busy, 0);
    chk("rst_xfer_done", xfer_done, 0);
    reset_n = 1'b1;
    wq;

    for (int v = 0; v < 8; v++) begin
      wb = wcnt; xb = xd_cnt; bb = busy_cyc; ob = oe_cyc;
      acks = 4'b0000;
      i2c_start;
      for (int i = 0; i < tbl[v].nb; i++) begin
        bv = tbl[v].b[31-8*i -: 8];
        send_byte(bv, ack);
        acks[i] = ack;
      end
      i2c_stop;
      wq;
      chk($sformatf("v%0d_acks", v), acks, tbl[v].ack_exp);
      chk($sformatf("v%0d_nwrites", v), wcnt - wb, tbl[v].nw);
      if (tbl[v].nw >= 1) begin
        chk($sformatf("v%0d_w0_addr", v), wa[wb], tbl[v].a0);
        chk($sformatf("v%0d_w0_data", v), wd[wb], tbl[v].d0);
      end
      if (tbl[v].nw >= 2) begin
        chk($sformatf("v%0d_w1_addr", v), wa[wb+1], tbl[v].a1);
        chk($sformatf("v%0d_w1_data", v), wd[wb+1], tbl[v].d1);
      end
      chk($sformatf("v%0d_page", v), page, tbl[v].page_exp);
      chk($sformatf("v%0d_xfer_done", v), xd_cnt - xb, tbl[v].xd_exp);
      chk($sformatf("v%0d_busy_seen", v), (busy_cyc - bb) > 0, tbl[v].busy_exp);
      if (tbl[v].ack_exp == 4'b0000)
        chk($sformatf("v%0d_sda_oe_cycles", v), oe_cyc - ob, 0);
      chk($sformatf("v%0d_busy_after_stop", v), busy, 0);
    end

    // Repeated START abandons the pointer-only transfer; second one writes
    wb = wcnt; xb = xd_cnt;
    i2c_start;
    send_byte(8'h20, ack);
    send_byte(8'h34, ack);
    i2c_rep_start;
    send_byte(8'h20, ack);
    chk("sr_addr_ack", ack, 1);
    send_byte(8'h56, ack);
    send_byte(8'h77, ack);
    i2c_stop;
    wq;
    chk("sr_nwrites", wcnt - wb, 1);
    chk("sr_w_addr", wa[wb], 16'h0556);
    chk("sr_w_data", wd[wb], 8'h77);
    chk("sr_xfer_done", xd_cnt - xb, 1);

    // Partial byte before STOP is dropped
    wb = wcnt;
    i2c_start;
    send_byte(8'h20, ack);
    send_byte(8'h40, ack);
    i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b1); i2c_bit(1'b0);
    i2c_stop;
    wq;
    chk("partial_nwrites", wcnt - wb, 0);

    // Reset asserted while the slave is driving the data-byte ACK
    i2c_start;
    send_byte(8'h20, ack);
    send_byte(8'h34, ack);
    wb = wcnt;
    bv = 8'hAB;
    for (int i = 7; i >= 0; i--) i2c_bit(bv[i]);
    chk("rstack_pre_nwrites", wcnt - wb, 1);
    chk("rstack_pre_addr", wa[wb], 16'h0534);
    chk("rstack_pre_data", wd[wb], 8'hAB);
    sda_m = 1'b1; wq;
    scl = 1'b1; wq;
    chk("rstack_ack_driven", sda_oe, 1);
    reset_n = 1'b0;
    #1;
    chk("rstack_sda_oe_async", sda_oe, 0);
    chk("rstack_page_async", page, 0);
    wb = wcnt; xb = xd_cnt;
    wq;
    scl = 1'b0; wq;
    reset_n = 1'b1; wq;
    i2c_stop;
    wq;
    chk("rstack_post_nwrites", wcnt - wb, 0);
    chk("rstack_post_page", page, 0);
    chk("rstack_post_busy", busy, 0);
    chk("rstack_post_xfer_done", xd_cnt - xb, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
